// File: rtl/guess_pkg.sv
// Shared state encodings and result codes for the guessing-game decision logic.
package guess_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_e;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LOW  = 2'b01;
  localparam logic [1:0] RES_HIGH = 2'b10;
  localparam logic [1:0] RES_EQ   = 2'b11;

endpackage

// File: rtl/guess_decision_fsm_compare.sv
// Combinational unsigned comparator: maps (guess, secret) to a 2-bit result code.
module guess_compare
  import guess_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] guess,
  input  logic [WIDTH-1:0] secret,
  output logic [1:0]       code
);

  always_comb begin
    if (guess == secret)     code = RES_EQ;
    else if (guess < secret) code = RES_LOW;
    else                     code = RES_HIGH;
  end

endmodule

// File: rtl/guess_decision_fsm.sv
// Game FSM: latches a secret on start, grades strobed guesses, counts attempts,
// and ends each game in WIN or LOSE.
module guess_decision_fsm
  import guess_pkg::*;
#(
  parameter  int WIDTH     = 2,
  parameter  int MAX_TRIES = 4,
  localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] secret,
  input  logic             guess_valid,
  input  logic [WIDTH-1:0] guess,
  output logic [1:0]       result,
  output logic             result_valid,
  output logic [TRY_W-1:0] tries,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [TRY_W-1:0] TRY_SAT  = '1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   secret_q, secret_d;
  logic [1:0]         result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [1:0]         cmp_code;

  guess_compare #(.WIDTH(WIDTH)) u_compare (
    .guess  (guess),
    .secret (secret_q),
    .code   (cmp_code)
  );

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    secret_d       = secret_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    tries_d        = tries_q;

    unique case (state_q)
      S_PLAY: begin
        if (guess_valid) begin
          result_d       = cmp_code;
          result_valid_d = 1'b1;
          if (tries_q != TRY_SAT) tries_d = tries_q + 1'b1;
          if (cmp_code == RES_EQ)       state_d = S_WIN;
          else if (tries_q == LAST_TRY) state_d = S_LOSE;
        end
      end
      // IDLE, WIN and LOSE all restart identically; guesses are ignored here.
      default: begin
        if (start) begin
          secret_d = secret;
          tries_d  = '0;
          result_d = RES_NONE;
          state_d  = S_PLAY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      // NOTE: the secret register is cleared too, so no stale value survives a reset.
      state_q        <= S_IDLE;
      secret_q       <= '0;
      result_q       <= RES_NONE;
      result_valid_q <= 1'b0;
      tries_q        <= '0;
    end else begin
      state_q        <= state_d;
      secret_q       <= secret_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      tries_q        <= tries_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign tries        = tries_q;
  assign busy         = (state_q == S_PLAY);
  assign win          = (state_q == S_WIN);
  assign lose         = (state_q == S_LOSE);

endmodule

// File: tb/tb_guess_decision_fsm.sv
// Directed bench: default 2-bit/4-try instance plus an 8-bit/7-try instance.
module tb_guess_decision_fsm;

  logic       clk = 1'b0;
  logic       reset;

  logic       start_a, gv_a;
  logic [1:0] secret_a, guess_a;
  logic [1:0] result_a;
  logic       rv_a, busy_a, win_a, lose_a;
  logic [2:0] tries_a;

  logic       start_b, gv_b;
  logic [7:0] secret_b, guess_b;
  logic [1:0] result_b;
  logic       rv_b, busy_b, win_b, lose_b;
  logic [2:0] tries_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  guess_decision_fsm #(.WIDTH(2), .MAX_TRIES(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .secret(secret_a),
    .guess_valid(gv_a), .guess(guess_a), .result(result_a),
    .result_valid(rv_a), .tries(tries_a), .busy(busy_a), .win(win_a), .lose(lose_a)
  );

  guess_decision_fsm #(.WIDTH(8), .MAX_TRIES(7)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .secret(secret_b),
    .guess_valid(gv_b), .guess(guess_b), .result(result_b),
    .result_valid(rv_b), .tries(tries_b), .busy(busy_b), .win(win_b), .lose(lose_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags_a(input string tag, input logic b, input logic w, input logic l);
    check({tag, ".busy"}, 32'(busy_a), 32'(b));
    check({tag, ".win"},  32'(win_a),  32'(w));
    check({tag, ".lose"}, 32'(lose_a), 32'(l));
  endtask

  task automatic guess_step_a(input string tag, input logic [1:0] g,
                              input logic [1:0] exp_res, input int exp_tries);
    gv_a = 1'b1; guess_a = g;
    tick();
    gv_a = 1'b0;
    check({tag, ".rv"},    32'(rv_a),     32'd1);
    check({tag, ".res"},   32'(result_a), 32'(exp_res));
    check({tag, ".tries"}, 32'(tries_a),  32'(exp_tries));
  endtask

  task automatic guess_step_b(input string tag, input logic [7:0] g,
                              input logic [1:0] exp_res, input int exp_tries);
    gv_b = 1'b1; guess_b = g;
    tick();
    gv_b = 1'b0;
    check({tag, ".rv"},    32'(rv_b),     32'd1);
    check({tag, ".res"},   32'(result_b), 32'(exp_res));
    check({tag, ".tries"}, 32'(tries_b),  32'(exp_tries));
  endtask

  initial begin
    reset = 1'b1;
    start_a = 0; gv_a = 0; secret_a = 0; guess_a = 0;
    start_b = 0; gv_b = 0; secret_b = 0; guess_b = 0;

    // Reset and idle behaviour
    tick(); tick();
    check("rst.res", 32'(result_a), 32'd0);
    check("rst.rv",  32'(rv_a),     32'd0);
    check("rst.tries", 32'(tries_a), 32'd0);
    check_flags_a("rst", 0, 0, 0);
    reset = 1'b0;
    gv_a = 1'b1; guess_a = 2'b01;
    tick();
    gv_a = 1'b0;
    check("idle_guess.rv", 32'(rv_a), 32'd0);
    check_flags_a("idle_guess", 0, 0, 0);

    // Win path; secret input changes after latch must not matter
    secret_a = 2'b10; start_a = 1'b1;
    tick();
    start_a = 1'b0; secret_a = 2'b00;
    check_flags_a("win.start", 1, 0, 0);
    check("win.start.tries", 32'(tries_a), 32'd0);
    guess_step_a("win.g0", 2'b00, 2'b01, 1);
    tick();
    check("win.g0.rv_drop", 32'(rv_a), 32'd0);
    check("win.g0.res_hold", 32'(result_a), 32'b01);
    guess_step_a("win.g1", 2'b11, 2'b10, 2);
    guess_step_a("win.g2", 2'b10, 2'b11, 3);
    check_flags_a("win.end", 0, 1, 0);
    gv_a = 1'b1; guess_a = 2'b00;
    tick();
    gv_a = 1'b0;
    check("win.ignored.rv", 32'(rv_a), 32'd0);
    check("win.ignored.res", 32'(result_a), 32'b11);
    check("win.ignored.tries", 32'(tries_a), 32'd3);

    // Restart from WIN with a simultaneous strobe
    secret_a = 2'b01; start_a = 1'b1; gv_a = 1'b1; guess_a = 2'b01;
    tick();
    start_a = 1'b0; gv_a = 1'b0;
    check_flags_a("restart", 1, 0, 0);
    check("restart.tries", 32'(tries_a), 32'd0);
    check("restart.res",   32'(result_a), 32'd0);
    check("restart.rv",    32'(rv_a), 32'd0);
    gv_a = 1'b1; guess_a = 2'b01;
    tick();
    check("b2b.first.rv",  32'(rv_a), 32'd1);
    check("b2b.first.res", 32'(result_a), 32'b11);
    check("b2b.first.tries", 32'(tries_a), 32'd1);
    tick();
    gv_a = 1'b0;
    check("b2b.second.rv", 32'(rv_a), 32'd0);
    check("b2b.second.tries", 32'(tries_a), 32'd1);
    check_flags_a("b2b.end", 0, 1, 0);

    // Lose path
    secret_a = 2'b11; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    guess_step_a("lose.g0", 2'b00, 2'b01, 1);
    guess_step_a("lose.g1", 2'b01, 2'b01, 2);
    guess_step_a("lose.g2", 2'b10, 2'b01, 3);
    check_flags_a("lose.mid", 1, 0, 0);
    guess_step_a("lose.g3", 2'b00, 2'b01, 4);
    check_flags_a("lose.end", 0, 0, 1);
    gv_a = 1'b1; guess_a = 2'b11;
    tick();
    gv_a = 1'b0;
    check("lose.fifth.rv",    32'(rv_a), 32'd0);
    check("lose.fifth.tries", 32'(tries_a), 32'd4);
    check("lose.fifth.res",   32'(result_a), 32'b01);

    // Reset mid-game
    secret_a = 2'b01; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    guess_step_a("mid.g0", 2'b00, 2'b01, 1);
    guess_step_a("mid.g1", 2'b11, 2'b10, 2);
    reset = 1'b1; gv_a = 1'b1; guess_a = 2'b01;
    tick();
    reset = 1'b0; gv_a = 1'b0;
    check("mid.rst.tries", 32'(tries_a), 32'd0);
    check("mid.rst.res",   32'(result_a), 32'd0);
    check("mid.rst.rv",    32'(rv_a), 32'd0);
    check_flags_a("mid.rst", 0, 0, 0);
    secret_a = 2'b10; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_flags_a("mid.restart", 1, 0, 0);
    guess_step_a("mid.win", 2'b10, 2'b11, 1);
    check_flags_a("mid.win", 0, 1, 0);

    // Wide instance: unsigned compare and MAX_TRIES=7
    check("w.idle.busy", 32'(busy_b), 32'd0);
    secret_b = 8'd200; start_b = 1'b1;
    tick();
    start_b = 1'b0; secret_b = 8'd255;
    check("w.start.busy", 32'(busy_b), 32'd1);
    guess_step_b("w.g255", 8'd255, 2'b10, 1);
    guess_step_b("w.g0",   8'd0,   2'b01, 2);
    guess_step_b("w.g199", 8'd199, 2'b01, 3);
    guess_step_b("w.g201", 8'd201, 2'b10, 4);
    guess_step_b("w.g1",   8'd1,   2'b01, 5);
    guess_step_b("w.g254", 8'd254, 2'b10, 6);
    check("w.mid.busy", 32'(busy_b), 32'd1);
    guess_step_b("w.g100", 8'd100, 2'b01, 7);
    check("w.end.lose",  32'(lose_b), 32'd1);
    check("w.end.busy",  32'(busy_b), 32'd0);
    check("w.end.win",   32'(win_b),  32'd0);
    check("w.end.tries", 32'(tries_b), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
